// File: rtl/mod_exp_pkg.sv
// rtl/mod_exp_pkg.sv - shared FSM states, error codes and multiplier timing for mod_exp_engine
package mod_exp_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      SQR    = 3'd2,
      MUL    = 3'd3,
      FINISH = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE       = 2'd0,
      ERR_MOD_ZERO   = 2'd1,
      ERR_BASE_RANGE = 2'd2
   } err_code_e;

   // Clock cycles one modular multiply occupies, load cycle included.
   function automatic int mul_cycles(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/mod_exp_engine_mul.sv
// rtl/mod_exp_engine_mul.sv - sequential interleaved modular multiplier (mod_mul), one product bit per cycle
module mod_mul
   import mod_exp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] m,
   output logic             done,
   output logic [WIDTH-1:0] p
);

   localparam int STEPS = mul_cycles(WIDTH) - 1;

   logic [WIDTH-1:0] a_q, b_q, m_q, p_q, p_d;
   logic [CNT_W-1:0] cnt_q;
   logic             run_q, done_q;
   logic [WIDTH:0]   dbl, dbl_red, sum, sum_red;

   // p < m and a < m keep every intermediate below 2m, so WIDTH+1 bits suffice.
   always_comb begin
      dbl     = {p_q, 1'b0};
      dbl_red = (dbl >= {1'b0, m_q}) ? dbl - {1'b0, m_q} : dbl;
      sum     = dbl_red + (b_q[WIDTH-1] ? {1'b0, a_q} : '0);
      sum_red = (sum >= {1'b0, m_q}) ? sum - {1'b0, m_q} : sum;
      p_d     = WIDTH'(sum_red);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         m_q    <= '0;
         p_q    <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            a_q   <= a;
            b_q   <= b;
            m_q   <= m;
            p_q   <= '0;
            cnt_q <= CNT_W'(STEPS);
            run_q <= 1'b1;
         end else if (run_q) begin
            p_q   <= p_d;
            b_q   <= b_q << 1;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done = done_q;
   assign p    = p_q;

endmodule

// File: rtl/mod_exp_engine.sv
// rtl/mod_exp_engine.sv - MSB-first square-and-multiply modexp; MOD_EXP_CONST_TIME_EN forces a multiply per exponent bit
module mod_exp_engine
   import mod_exp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0] modulus,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);

   state_e           state_q, state_d;
   err_code_e        err_code_q, err_code_d;
   logic [WIDTH-1:0] base_q, exp_q, mod_q;
   logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d;
   logic [CNT_W-1:0] i_q, i_d;
   logic             done_q, done_d, err_q, err_d;
   logic             mul_start, mul_done;
   logic [WIDTH-1:0] mul_a, mul_b, mul_p;
   logic             exp_bit, last_bit, op_bad, op_one;

   assign exp_bit  = |(exp_q & (WIDTH'(1) << i_q));
   assign last_bit = (i_q == '0);
   assign op_bad   = (mod_q == '0) || (base_q >= mod_q);
   assign op_one   = (mod_q == WIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (start) state_d = CHECK;
         CHECK:  state_d = (op_bad || op_one) ? FINISH : SQR;
         SQR: if (mul_done) begin
`ifdef MOD_EXP_CONST_TIME_EN
            state_d = MUL;
`else
            if (exp_bit)       state_d = MUL;
            else if (last_bit) state_d = FINISH;
            else               state_d = SQR;
`endif
         end
         MUL:    if (mul_done) state_d = last_bit ? FINISH : SQR;
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next operands are taken from acc_d so a new multiply starts in the same cycle the previous one retires.
   always_comb begin
      acc_d      = acc_q;
      i_d        = i_q;
      err_code_d = err_code_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      result_d   = result_q;
      mul_start  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            acc_d      = WIDTH'(1);
            i_d        = CNT_W'(WIDTH - 1);
            err_code_d = ERR_NONE;
         end
         CHECK: begin
            if (mod_q == '0)          err_code_d = ERR_MOD_ZERO;
            else if (base_q >= mod_q) err_code_d = ERR_BASE_RANGE;
            if (op_bad || op_one) acc_d = '0;
            mul_start = (state_d == SQR);
         end
         SQR: if (mul_done) begin
            acc_d     = mul_p;
            if (state_d == SQR) i_d = i_q - CNT_W'(1);
            mul_start = (state_d != FINISH);
         end
         MUL: if (mul_done) begin
`ifdef MOD_EXP_CONST_TIME_EN
            if (exp_bit) acc_d = mul_p;
`else
            acc_d = mul_p;
`endif
            if (state_d == SQR) i_d = i_q - CNT_W'(1);
            mul_start = (state_d == SQR);
         end
         FINISH: begin
            done_d   = 1'b1;
            err_d    = (err_code_q != ERR_NONE);
            result_d = acc_q;
         end
         default: ;
      endcase
      mul_a = acc_d;
      mul_b = (state_d == MUL) ? base_q : acc_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_q     <= '0;
         exp_q      <= '0;
         mod_q      <= '0;
         acc_q      <= '0;
         i_q        <= '0;
         err_code_q <= ERR_NONE;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         result_q   <= '0;
      end else begin
         if (state_q == IDLE && start) begin
            base_q <= base;
            exp_q  <= exponent;
            mod_q  <= modulus;
         end
         acc_q      <= acc_d;
         i_q        <= i_d;
         err_code_q <= err_code_d;
         done_q     <= done_d;
         err_q      <= err_d;
         result_q   <= result_d;
      end
   end

   mod_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (mul_start),
      .a     (mul_a),
      .b     (mul_b),
      .m     (mod_q),
      .done  (mul_done),
      .p     (mul_p)
   );

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// tb/tb_mod_exp_engine.sv - randomized self-checking bench for mod_exp_engine against a behavioural model
module tb_mod_exp_engine;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] base = '0, exponent = '0, modulus = '0;
   logic         busy, done, err;
   logic [W-1:0] result;

   int           n_cmp = 0, n_bad = 0;
   int           cyc = 0;
   bit           pending = 1'b0, got_done = 1'b0, quiet = 1'b0;
   int           t0 = 0, exp_lat = 0;
   logic [W-1:0] exp_res = '0, held_res = '0;
   bit           exp_err = 1'b0;

   mod_exp_engine #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .base     (base),
      .exponent (exponent),
      .modulus  (modulus),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .result   (result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
      logic [63:0] r;
      if (m == 0 || b >= m || m == 1) return '0;
      r = 64'd1;
      for (int i = W - 1; i >= 0; i--) begin
         r = (r * r) % {32'd0, m};
         if (e[i]) r = (r * {32'd0, b}) % {32'd0, m};
      end
      return r[W-1:0];
   endfunction

   function automatic int ref_lat(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
      if (m == 0 || b >= m || m == 1) return 2;
`ifdef MOD_EXP_CONST_TIME_EN
      return 2 + 2 * (W + 1) * W;
`else
      return 2 + (W + 1) * (W + $countones(e));
`endif
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && !quiet) begin
         if (pending && cyc >= t0) begin
            if (cyc - t0 == exp_lat) begin
               check("done_pulse", W'(done), W'(1));
               check("busy_at_done", W'(busy), W'(0));
               check("result", result, exp_res);
               check("err", W'(err), W'(exp_err));
               held_res = exp_res;
               pending  = 1'b0;
               got_done = 1'b1;
            end else begin
               check("done_early", W'(done), W'(0));
               check("busy_running", W'(busy), W'(1));
            end
         end else if (!pending) begin
            check("done_idle", W'(done), W'(0));
            check("busy_idle", W'(busy), W'(0));
            check("result_held", result, held_res);
         end
      end
   end

   task automatic run(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m, input bit poke);
      @(posedge clk); #1;
      base = b; exponent = e; modulus = m; start = 1'b1;
      exp_res  = ref_pow(b, e, m);
      exp_err  = (m == 0) || (b >= m);
      exp_lat  = ref_lat(b, e, m);
      t0       = cyc + 1;
      got_done = 1'b0;
      pending  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      base = $urandom; exponent = $urandom; modulus = $urandom;
      for (int k = 0; k < exp_lat + 10 && !got_done; k++) begin
         if (poke && k == 5) begin
            start = 1'b1; base = 32'd3; exponent = 32'd7; modulus = 32'd11;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      if (!got_done) begin
         check("done_timeout", W'(0), W'(1));
         pending = 1'b0;
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL global_timeout: got no finish, expected finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      logic [W-1:0] rb, re, rm;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", W'(busy), W'(0));
      check("reset_done", W'(done), W'(0));
      check("reset_err", W'(err), W'(0));
      check("reset_result", result, W'(0));
      rst = 1'b0;

      check("model_5_6_23", ref_pow(32'd5, 32'd6, 32'd23), 32'd8);
      check("model_5_0_23", ref_pow(32'd5, 32'd0, 32'd23), 32'd1);
      check("model_5_3_23", ref_pow(32'd5, 32'd3, 32'd23), 32'd10);
      check("model_2_1_p", ref_pow(32'd2, 32'd1, 32'hFFFFFFFB), 32'd2);
`ifdef MOD_EXP_CONST_TIME_EN
      check("lat_5_6_23", W'(ref_lat(32'd5, 32'd6, 32'd23)), 32'd2114);
      check("lat_2_1_p", W'(ref_lat(32'd2, 32'd1, 32'hFFFFFFFB)), 32'd2114);
`else
      check("lat_5_6_23", W'(ref_lat(32'd5, 32'd6, 32'd23)), 32'd1124);
      check("lat_2_1_p", W'(ref_lat(32'd2, 32'd1, 32'hFFFFFFFB)), 32'd1091);
`endif
      check("lat_2_f_p", W'(ref_lat(32'd2, 32'hFFFFFFFF, 32'hFFFFFFFB)), 32'd2114);
      check("lat_err", W'(ref_lat(32'd30, 32'd5, 32'd23)), 32'd2);

      run(32'd5, 32'd6, 32'd23, 1'b0);
      run(32'd5, 32'd0, 32'd23, 1'b0);
      run(32'd5, 32'd3, 32'd23, 1'b0);
      run(32'd7, 32'd123, 32'd0, 1'b0);
      run(32'd30, 32'd5, 32'd23, 1'b0);
      run(32'd23, 32'd1, 32'd23, 1'b0);
      run(32'd0, 32'd9, 32'd1, 1'b0);
      run(32'd5, 32'd6, 32'd23, 1'b1);

      // Abort mid-SQR with reset, then confirm a clean restart.
      quiet = 1'b1;
      @(posedge clk); #1;
      base = 32'd5; exponent = 32'd6; modulus = 32'd23; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("busy_before_abort", W'(busy), W'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", W'(busy), W'(0));
      check("abort_done", W'(done), W'(0));
      check("abort_result", result, W'(0));
      rst = 1'b0;
      held_res = '0;
      quiet = 1'b0;
      repeat (40) @(posedge clk);
      run(32'd5, 32'd3, 32'd23, 1'b0);

      run(32'd2, 32'd1, 32'hFFFFFFFB, 1'b0);
      run(32'd2, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0);

      for (int n = 0; n < 16; n++) begin
         rm = (n % 2 == 1) ? W'($urandom_range(1000, 2)) : W'($urandom);
         if (rm < 2) rm = 32'd2;
         rb = W'($urandom) % rm;
         re = W'($urandom);
         run(rb, re, rm, 1'b0);
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
